// File: rtl/seq_add_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM state
// encodings and a ceil-log2 helper used to size the step counter.
package seq_add_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Ceil-log2 with a floor of 1, so a single-step build still gets a
  // one-bit counter instead of a zero-width vector.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder; DIGIT copies form the per-step ripple chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry of a single bit position.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end

endmodule

// File: rtl/seq_ripple_adder.sv
// Multi-cycle ripple adder/subtractor: WIDTH-bit operands, DIGIT bits per
// clock, carry held in a register between steps.
// Optional build macro: SEQ_ADD_OVF_EN adds the registered signed-overflow
// output ovf; without it the port and its logic are absent.
//
// Handshake: start is sampled only in IDLE or DONE; a sampled start latches
// a/b/sub/cin and moves to RUN. busy is high for exactly the STEPS RUN
// cycles. done is a one-cycle pulse (DONE state) in which sum/cout/ovf are
// freshly valid; they hold until the next done or reset. start while busy
// is dropped, not queued.
module seq_ripple_adder
  import seq_add_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SEQ_ADD_OVF_EN
  output logic             ovf,
`endif
  output state_t           dbg_state
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = clog2_min1(STEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("seq_ripple_adder: WIDTH must be an integer multiple of DIGIT");
  end

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [CW-1:0]      r_step;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic [WIDTH-1:0]   w_full;
  logic [DIGIT:0]     w_c;
  logic [DIGIT-1:0]   w_s;
  logic               w_load;
  logic               w_run;
  logic               w_last;

  assign w_load = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_run  = (r_state == S_RUN);
  assign w_last = w_run && (r_step == LAST_STEP);

  // Per-step ripple chain over the low DIGIT bits of the operand shifters.
  assign w_c[0] = r_carry;
  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (r_a[i]),
      .b  (r_b[i]),
      .ci (w_c[i]),
      .s  (w_s[i]),
      .co (w_c[i+1])
    );
  end

  // Partial result: new digits enter at the top, older ones drift down, so
  // after STEPS shifts the first digit sits at bit 0.
  if (DIGIT < WIDTH) begin : g_part
    logic [WIDTH-DIGIT-1:0] r_part;
    assign w_full = {w_s, r_part};
    // Shift the partial-result register once per RUN cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_part <= '0;
      end else if (w_run) begin
        r_part <= w_full[WIDTH-1:DIGIT];
      end
    end
  end else begin : g_nopart
    assign w_full = w_s;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = start ? S_RUN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand load, per-step shift/carry update and final result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_step  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_load) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : cin;
      r_step  <= '0;
    end else if (w_run) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_carry <= w_c[DIGIT];
      r_step  <= r_step + CW'(1);
      if (w_last) begin
        r_sum  <= w_full;
        r_cout <= w_c[DIGIT];
      end
    end
  end

`ifdef SEQ_ADD_OVF_EN
  logic r_ovf;
  // Signed overflow: carry into the MSB differs from carry out of it; the
  // MSB is the top cell of the final step.
  always_ff @(posedge clk) begin
    if (rst)         r_ovf <= 1'b0;
    else if (w_last) r_ovf <= w_c[DIGIT] ^ w_c[DIGIT-1];
  end
  assign ovf = r_ovf;
`endif

  assign sum       = r_sum;
  assign cout      = r_cout;
  assign dbg_state = r_state;

endmodule
